// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with a branch look-up table.
//
// Walks the PC sequentially from 0 after start and redirects it through an
// external combinational LUT on taken branches. A halt, or sequential fetch
// past PC_LAST, ends the program.
//
// Parameters
//   ADDR_I_W  branch LUT index width
//   PC_W      program counter width (also the LUT entry width)
//   PC_LAST   final legal PC for sequential fetch
//
// Ports
//   clk         single clock, rising edge
//   reset_n     synchronous active-low reset
//   start       one-cycle pulse, begins execution at PC 0 (IDLE/DONE only)
//   branch_req  decode reports a taken branch for the current PC
//   branch_sel  LUT index of the branch target
//   halt_req    decode reports a halt instruction
//   stall       freeze the PC this cycle
//   lut_addr    registered index driven to the branch LUT
//   lut_out     LUT read data for lut_addr
//   pc          current instruction address
//   running     high in FETCH or BRANCH
//   done        high in DONE
//   branch_cnt  taken branches since the last start, saturating
//
// state  | meaning
// IDLE   | after reset, PC held until start
// FETCH  | normal execution: halt > stall > branch > increment
// BRANCH | lut_addr is valid, PC loads lut_out this cycle
// DONE   | program ended (halt or past PC_LAST), waits for start

module pc_seq #(
    parameter int                ADDR_I_W = 8,
    parameter int                PC_W     = 16,
    parameter logic [PC_W-1:0]   PC_LAST  = {PC_W{1'b1}}
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                branch_req,
    input  logic [ADDR_I_W-1:0] branch_sel,
    input  logic                halt_req,
    input  logic                stall,
    output logic [ADDR_I_W-1:0] lut_addr,
    input  logic [PC_W-1:0]     lut_out,
    output logic [PC_W-1:0]     pc,
    output logic                running,
    output logic                done,
    output logic [PC_W-1:0]     branch_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        BRANCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [PC_W-1:0]     pc_nxt;
    logic [ADDR_I_W-1:0] lut_addr_nxt;
    logic [PC_W-1:0]     branch_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= '0;
            lut_addr   <= '0;
            branch_cnt <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            lut_addr   <= lut_addr_nxt;
            branch_cnt <= branch_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        lut_addr_nxt   = lut_addr;
        branch_cnt_nxt = branch_cnt;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt      = FETCH;
                    pc_nxt         = '0;
                    branch_cnt_nxt = '0;
                end
            end
            FETCH: begin
                if (halt_req) begin
                    state_nxt = DONE;
                end else if (stall) begin
                    // hold everything; a branch here is dropped, decode re-presents it
                    state_nxt = FETCH;
                end else if (branch_req) begin
                    state_nxt    = BRANCH;
                    lut_addr_nxt = branch_sel;
                    if (branch_cnt != {PC_W{1'b1}})
                        branch_cnt_nxt = branch_cnt + PC_ONE;
                end else if (pc == PC_LAST) begin
                    // exact compare: targets above PC_LAST keep counting up
                    state_nxt = DONE;
                end else begin
                    pc_nxt = pc + PC_ONE;
                end
            end
            BRANCH: begin
                state_nxt = FETCH;
                pc_nxt    = lut_out;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign running = (state == FETCH) || (state == BRANCH);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed bench for pc_seq with a small LUT model.
// PC_LAST is set to 10 so program end is reachable; branch targets at 0x40
// sit above PC_LAST and exercise the exact-compare rule.

module tb_pc_seq;

    localparam int              ADDR_I_W = 8;
    localparam int              PC_W     = 16;
    localparam logic [PC_W-1:0] PC_LAST  = 16'h000A;

    logic                clk;
    logic                reset_n;
    logic                start;
    logic                branch_req;
    logic [ADDR_I_W-1:0] branch_sel;
    logic                halt_req;
    logic                stall;
    logic [ADDR_I_W-1:0] lut_addr;
    logic [PC_W-1:0]     lut_out;
    logic [PC_W-1:0]     pc;
    logic                running;
    logic                done;
    logic [PC_W-1:0]     branch_cnt;

    int total = 0;
    int bad   = 0;

    pc_seq #(
        .ADDR_I_W (ADDR_I_W),
        .PC_W     (PC_W),
        .PC_LAST  (PC_LAST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .branch_req (branch_req),
        .branch_sel (branch_sel),
        .halt_req   (halt_req),
        .stall      (stall),
        .lut_addr   (lut_addr),
        .lut_out    (lut_out),
        .pc         (pc),
        .running    (running),
        .done       (done),
        .branch_cnt (branch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LUT model: entries 3 and 8 both point at 0x0040, others are distinct
    always_comb begin
        case (lut_addr)
            8'd3:    lut_out = 16'h0040;
            8'd8:    lut_out = 16'h0040;
            default: lut_out = {8'hA5, lut_addr};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        branch_req = 1'b0;
        branch_sel = '0;
        halt_req   = 1'b0;
        stall      = 1'b0;

        // reset
        tick(); tick();
        check("rst_pc", pc, 0);
        check("rst_lut_addr", lut_addr, 0);
        check("rst_cnt", branch_cnt, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);

        reset_n = 1'b1;
        tick();
        check("idle_running", running, 0);
        check("idle_pc", pc, 0);

        // sequential run 0..4
        start = 1'b1;
        tick();
        start = 1'b0;
        check("seq_pc0", pc, 0);
        check("seq_running", running, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("seq_pc", pc, k);
        end
        check("seq_done", done, 0);

        // branch at pc 5 through LUT[3]
        tick();
        check("pre_br_pc", pc, 5);
        branch_req = 1'b1;
        branch_sel = 8'd3;
        tick();
        branch_req = 1'b0;
        check("br_lut_addr", lut_addr, 3);
        check("br_pc_hold", pc, 5);
        check("br_running", running, 1);
        tick();
        check("br_pc_target", pc, 16'h0040);
        check("br_cnt", branch_cnt, 1);

        // self-loop: LUT[8] is the current pc
        branch_req = 1'b1;
        branch_sel = 8'd8;
        tick();
        branch_req = 1'b0;
        check("loop_lut_addr", lut_addr, 8);
        tick();
        check("loop_pc", pc, 16'h0040);
        check("loop_cnt", branch_cnt, 2);
        tick();
        check("above_last_pc", pc, 16'h0041);

        // halt wins over stall and branch
        halt_req   = 1'b1;
        stall      = 1'b1;
        branch_req = 1'b1;
        branch_sel = 8'd9;
        tick();
        halt_req = 1'b0;
        check("halt_done", done, 1);
        check("halt_running", running, 0);
        check("halt_pc", pc, 16'h0041);
        check("halt_cnt", branch_cnt, 2);
        check("halt_lut_addr", lut_addr, 8);
        // DONE ignores stall/branch
        tick();
        stall      = 1'b0;
        branch_req = 1'b0;
        check("done_hold_pc", pc, 16'h0041);
        check("done_hold", done, 1);

        // restart from DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_pc", pc, 0);
        check("restart_cnt", branch_cnt, 0);
        check("restart_done", done, 0);

        // stall 3 cycles at pc 4, branch pulsed in the middle
        for (int k = 0; k < 4; k++) tick();
        check("pre_stall_pc", pc, 4);
        stall = 1'b1;
        tick();
        check("stall1_pc", pc, 4);
        branch_req = 1'b1;
        branch_sel = 8'd9;
        tick();
        branch_req = 1'b0;
        check("stall2_pc", pc, 4);
        check("stall2_lut_addr", lut_addr, 8);
        check("stall2_running", running, 1);
        tick();
        stall = 1'b0;
        check("stall3_pc", pc, 4);
        tick();
        check("stall_rel_pc", pc, 5);
        check("stall_cnt", branch_cnt, 0);

        // halt + stall + branch at pc 7
        tick(); tick();
        check("pre_halt7_pc", pc, 7);
        halt_req   = 1'b1;
        stall      = 1'b1;
        branch_req = 1'b1;
        tick();
        halt_req   = 1'b0;
        stall      = 1'b0;
        branch_req = 1'b0;
        check("halt7_done", done, 1);
        check("halt7_pc", pc, 7);
        check("halt7_cnt", branch_cnt, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("halt7_restart_pc", pc, 0);

        // run to PC_LAST, no wrap
        for (int k = 0; k < 10; k++) tick();
        check("last_pc", pc, 10);
        check("last_running", running, 1);
        tick();
        check("end_done", done, 1);
        check("end_pc", pc, 10);
        tick();
        check("end_nowrap_pc", pc, 10);
        check("end_running", running, 0);

        // branch above PC_LAST keeps counting sequentially
        start = 1'b1;
        tick();
        start = 1'b0;
        branch_req = 1'b1;
        branch_sel = 8'd3;
        tick();
        branch_req = 1'b0;
        tick();
        check("hi_target_pc", pc, 16'h0040);
        tick();
        check("hi_step_pc", pc, 16'h0041);
        check("hi_step_running", running, 1);

        // reset during BRANCH discards the target; start ignored under reset
        branch_req = 1'b1;
        branch_sel = 8'd7;
        tick();
        branch_req = 1'b0;
        check("mid_br_lut_addr", lut_addr, 7);
        reset_n = 1'b0;
        start   = 1'b1;
        tick();
        check("rstbr_pc", pc, 0);
        check("rstbr_lut_addr", lut_addr, 0);
        check("rstbr_cnt", branch_cnt, 0);
        check("rstbr_running", running, 0);
        check("rstbr_done", done, 0);
        start   = 1'b0;
        reset_n = 1'b1;
        tick();
        check("post_rst_running", running, 0);
        check("post_rst_pc", pc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL provide parameter ADDR_I_W, default 8, meaning the branch LUT index width.
REQ-002 SHALL provide parameter PC_W, default 16, meaning the program counter width, equal to the LUT entry width.
REQ-003 SHALL provide parameter PC_LAST, default 16'hFFFF, meaning the final legal PC; sequential fetch past it ends the program.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 start  in  1  single-cycle pulse; begins execution at PC 0.
REQ-007 branch_req  in  1  decode reports a taken branch for the current PC.
REQ-008 branch_sel  in  ADDR_I_W  LUT index of the branch target.
REQ-009 halt_req  in  1  decode reports a halt instruction.
REQ-010 stall  in  1  freeze PC this cycle.
REQ-011 lut_addr  out  ADDR_I_W  registered index driven to the branch LUT.
REQ-012 lut_out  in  PC_W  combinational LUT read data for lut_addr.
REQ-013 pc  out  PC_W  current instruction address.
REQ-014 running  out  1  high in FETCH or BRANCH.
REQ-015 done  out  1  high in DONE.
REQ-016 branch_cnt  out  PC_W  taken branches since the last start, saturating.

Function
REQ-017 SHALL implement the states IDLE, FETCH, BRANCH and DONE.
REQ-018 IDLE: pc holds; start -> pc<=0, branch_cnt<=0, go FETCH.
REQ-019 FETCH priority per cycle SHALL be halt_req > stall > branch_req > increment.
REQ-020 FETCH with halt_req -> go DONE, pc holds; stall and branch_req are ignored.
REQ-021 FETCH with stall and no halt_req -> pc, lut_addr and state hold; branch_req is ignored and decode must re-present it.
REQ-022 FETCH with branch_req -> lut_addr<=branch_sel, branch_cnt+1 (saturates at all ones), go BRANCH, pc holds.
REQ-023 FETCH otherwise: pc<=pc+1; if pc==PC_LAST, go DONE instead, pc holds (no wrap to 0).
REQ-024 BRANCH: pc<=lut_out (read through the registered lut_addr), go FETCH; branch_req, stall and halt_req are ignored in this cycle.
REQ-025 SHALL have a branch latency of 2 cycles from branch_req sampled to target visible on pc; sequential latency 1 cycle.
REQ-026 DONE: pc holds, done=1; start -> pc<=0, branch_cnt<=0, go FETCH; no other input has effect.
REQ-027 start SHALL be ignored in FETCH and BRANCH.
REQ-028 running and done SHALL be decoded from state only; never both high.
REQ-029 A lut_out target equal to current pc SHALL be legal (self-loop); no special case.
REQ-030 A branch target SHALL be taken verbatim even if above PC_LAST; the next sequential step from it obeys REQ-023 only when pc==PC_LAST exactly.

Reset
REQ-031 reset_n low at a clock edge SHALL force IDLE, pc=0, lut_addr=0, branch_cnt=0, running=0, done=0.
REQ-032 Reset SHALL dominate every other input in every state, including mid-BRANCH; the pending target is discarded.
REQ-033 Outputs SHALL be valid (reset values) from the first edge with reset_n low; no asynchronous path.

Verification
REQ-034 Reset 2 cycles, start pulse, no other inputs, 5 cycles -> pc 0,1,2,3,4; running=1, done=0.
REQ-035 LUT[3]=16'h0040; at pc=5 assert branch_req, branch_sel=3 for 1 cycle -> lut_addr=3 next cycle, pc=5 for 2 cycles, then pc=16'h0040, branch_cnt=1.
REQ-036 At pc=7 assert halt_req, stall and branch_req together -> DONE next cycle, pc=7, done=1, branch_cnt unchanged; start then -> pc=0, branch_cnt=0.
REQ-037 PC_LAST=16'h000A, run from start -> pc reaches 10, then done=1 with pc=10; never wraps to 0.
REQ-038 stall high 3 cycles at pc=4 with branch_req pulsed in the middle -> pc=4 throughout, no branch taken, branch_cnt unchanged, pc=5 after release.
REQ-039 reset_n low in the BRANCH cycle -> next cycle IDLE, pc=0, lut_addr=0, branch_cnt=0; start ignored while reset_n is low.
